// File: rtl/uart_pkg.sv
// Shared UART definitions: the receive/transmit frame-walking states used by
// uart_rx and intended for reuse by uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, WIDTH data bits, 1 stop bit, no parity.
// Oversamples with a free bit-timer that is re-phased on every start edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DIVISOR       = 86,
  parameter int SAMPLE_PHASE  = DIVISOR / 2,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_valid
);

  localparam int TIMER_W = $clog2(DIVISOR);
  localparam int CNT_W   = $clog2(WIDTH) + 1;

  localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(DIVISOR - 1);
  localparam logic [TIMER_W-1:0] PHASE_LAST = TIMER_W'(SAMPLE_PHASE - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WIDTH - 1);

  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  uart_state_e        state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   shift_d;
  logic               frame_err_q;
  logic [WIDTH-1:0]   data_q;
  logic               valid_q;

  logic start_edge;

  // NOTE: rx_prev_q resets to 0 so a line already low when reset is released
  // is not mistaken for a start edge; the line must be seen high first.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the flops a true shift chain
      // regardless of statement order.
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;

  // Drops the current sample into the word position owned by this bit count.
  always_comb begin
    shift_d = shift_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (bit_cnt_q == CNT_W'(k)) begin
        if (LITTLE_ENDIAN) shift_d[k] = rx_sync_q;
        else               shift_d[WIDTH-1-k] = rx_sync_q;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            timer_q <= '0;
            state_q <= START;
          end
        end

        START: begin
          if (timer_q == PHASE_LAST) begin
            if (!rx_sync_q) begin
              timer_q   <= '0;
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_q   <= '0;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_LAST) state_q <= STOP;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        STOP: begin
          // A broken stop bit parks here until the line idles high again.
          if (frame_err_q) begin
            if (rx_sync_q) begin
              frame_err_q <= 1'b0;
              state_q     <= IDLE;
            end
          end else if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            if (rx_sync_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one LSB-first and one MSB-first receiver share
// a serial line driven at nominal, +5% and -5% baud.
module tb_uart_rx;

  localparam int W   = 8;
  localparam int DIV = 86;
  localparam int P_NOM  = 86;
  localparam int P_FAST = 82;
  localparam int P_SLOW = 90;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_rx = 1'b1;
  logic [W-1:0] data_le, data_be;
  logic         valid_le, valid_be;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  logic [W-1:0] q_le[$];
  logic [W-1:0] q_be[$];
  logic [W-1:0] last_le = '0;
  logic [W-1:0] last_be = '0;
  logic         prev_valid_le = 1'b0;
  logic         prev_valid_be = 1'b0;
  int unsigned  vcyc_le = 0;
  int unsigned  t_start = 0;

  uart_rx #(.WIDTH(W), .DIVISOR(DIV), .SAMPLE_PHASE(DIV/2), .LITTLE_ENDIAN(1'b1)) u_le (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx), .o_data(data_le), .o_data_valid(valid_le)
  );

  uart_rx #(.WIDTH(W), .DIVISOR(DIV), .SAMPLE_PHASE(DIV/2), .LITTLE_ENDIAN(1'b0)) u_be (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx), .o_data(data_be), .o_data_valid(valid_be)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop on every valid pulse, otherwise the output must hold.
  always @(negedge clk) begin
    if (valid_le) begin
      check("le_pulse_one_cycle", 32'(prev_valid_le), 32'd0);
      if (q_le.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL le_unexpected_valid: got data 0x%0h, expected no pulse (cycle %0d)", data_le, cyc);
      end else begin
        last_le = q_le.pop_front();
        check("le_data", 32'(data_le), 32'(last_le));
        vcyc_le = cyc;
      end
    end else begin
      check("le_hold", 32'(data_le), 32'(last_le));
    end
    prev_valid_le = valid_le;
  end

  always @(negedge clk) begin
    if (valid_be) begin
      check("be_pulse_one_cycle", 32'(prev_valid_be), 32'd0);
      if (q_be.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL be_unexpected_valid: got data 0x%0h, expected no pulse (cycle %0d)", data_be, cyc);
      end else begin
        last_be = q_be.pop_front();
        check("be_data", 32'(data_be), 32'(last_be));
      end
    end else begin
      check("be_hold", 32'(data_be), 32'(last_be));
    end
    prev_valid_be = valid_be;
  end

  // Serializes one frame; good frames push the word each receiver should
  // reassemble from the line bits in arrival order.
  task automatic send_frame(input logic [W-1:0] b, input int period, input bit stop_ok);
    logic        line [W+2];
    logic [W-1:0] exp_le, exp_be;
    line[0] = 1'b0;
    for (int k = 0; k < W; k++) line[k+1] = b[k];
    line[W+1] = stop_ok;
    if (stop_ok) begin
      exp_le = '0;
      exp_be = '0;
      for (int k = 0; k < W; k++) begin
        if (line[k+1]) begin
          exp_le = exp_le | (W'(1) << k);
          exp_be = exp_be | (W'(1) << (W - 1 - k));
        end
      end
      q_le.push_back(exp_le);
      q_be.push_back(exp_be);
    end
    t_start = cyc;
    for (int i = 0; i < W + 2; i++) begin
      i_rx = line[i];
      repeat (period) @(negedge clk);
    end
    if (!stop_ok) repeat (40) @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] burst [4];
    int unsigned  lat;
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h3C; burst[3] = 8'h81;

    #10 i_reset = 1'b0;
    #1;
    check("reset_data_le", 32'(data_le), 32'd0);
    check("reset_data_be", 32'(data_be), 32'd0);
    check("reset_valid_le", 32'(valid_le), 32'd0);
    check("reset_valid_be", 32'(valid_be), 32'd0);
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    idle(20);

    send_frame(8'hA5, P_NOM, 1'b1);
    idle(20);
    lat = vcyc_le - t_start;
    check("latency_a5_in_window", 32'(lat >= 817 && lat <= 824), 32'd1);

    send_frame(8'h01, P_NOM, 1'b1);
    idle(20);

    for (int i = 0; i < 4; i++) send_frame(burst[i], P_FAST, 1'b1);
    idle(20);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), P_SLOW, 1'b1);
    idle(20);

    i_rx = 1'b0;
    repeat (10) @(negedge clk);
    idle(1000);
    check("glitch_no_pulse_le", 32'(data_le), 32'(last_le));

    send_frame(8'h55, P_NOM, 1'b0);
    idle(200);
    check("framing_err_hold_le", 32'(data_le), 32'(last_le));
    check("framing_err_hold_be", 32'(data_be), 32'(last_be));
    send_frame(8'h12, P_NOM, 1'b1);
    idle(20);

    send_frame(8'hC3, P_NOM, 1'b1);
    idle(100);
    i_rx = 1'b0;
    repeat (300) @(negedge clk);
    @(posedge clk);
    #1 i_reset = 1'b0;
    last_le = '0;
    last_be = '0;
    #1;
    check("midframe_reset_data_le", 32'(data_le), 32'd0);
    check("midframe_reset_data_be", 32'(data_be), 32'd0);
    check("midframe_reset_valid_le", 32'(valid_le), 32'd0);
    @(posedge clk);
    #1 i_reset = 1'b1;
    i_rx = 1'b1;
    idle(1000);
    send_frame(8'h7E, P_NOM, 1'b1);
    idle(20);

    for (int n = 0; n < 24; n++) begin
      int unsigned sel;
      int          per;
      sel = $urandom_range(2, 0);
      per = (sel == 0) ? P_FAST : (sel == 1) ? P_NOM : P_SLOW;
      send_frame(8'($urandom), per, ($urandom_range(5, 0) != 0));
      idle(int'($urandom_range(30, 0)));
    end

    idle(2000);
    check("le_queue_drained", 32'(q_le.size()), 32'd0);
    check("be_queue_drained", 32'(q_be.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
